// File: rtl/gcd_driver_if.sv
// Host request/response and GCD io_in/io_out signals bundled for the gcd_driver.
// slave is the driver's view; master is the host/GCD side.
interface gcd_driver_if #(parameter int W = 16);
    logic           req_valid;
    logic [2*W-1:0] req_data;
    logic           req_ready;
    logic           gcd_in_valid;
    logic [2*W-1:0] gcd_in_data;
    logic           gcd_in_ready;
    logic           gcd_out_valid;
    logic [W-1:0]   gcd_out_data;
    logic           rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           rsp_ready;
    logic           err;
    logic           err_clr;
    logic [15:0]    done_cnt;

    modport slave (
        input  req_valid, req_data, gcd_in_ready, gcd_out_valid, gcd_out_data,
               rsp_ready, err_clr,
        output req_ready, gcd_in_valid, gcd_in_data, rsp_valid, rsp_data,
               err, done_cnt
    );

    modport master (
        output req_valid, req_data, gcd_in_ready, gcd_out_valid, gcd_out_data,
               rsp_ready, err_clr,
        input  req_ready, gcd_in_valid, gcd_in_data, rsp_valid, rsp_data,
               err, done_cnt
    );
endinterface

// File: rtl/gcd_driver.sv
// Requester for the GCD unit: request FIFO -> one-at-a-time issue -> response FIFO.
// gcd(x,0) is answered locally since the GCD never terminates on y==0.
module gcd_driver_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module gcd_driver #(
    parameter int W         = 16,
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 1024
) (
    input logic         clk,
    input logic         reset,
    gcd_driver_if.slave bus
);
    // One extra bit so the saturated timer sits above TIMEOUT-1 and err fires once.
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           err_q, err_d;
    logic [15:0]    done_cnt_q, done_cnt_d;

    logic [2*W-1:0] req_head;
    logic           req_full, req_empty, req_pop;
    logic [W-1:0]   rsp_head, rsp_wdata;
    logic           rsp_full, rsp_empty, rsp_push;
    logic           err_set;

    gcd_driver_fifo #(.WIDTH(2*W), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.req_valid && !req_full),
        .wdata (bus.req_data),
        .pop   (req_pop),
        .rdata (req_head),
        .full  (req_full),
        .empty (req_empty)
    );

    gcd_driver_fifo #(.WIDTH(W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rsp_push),
        .wdata (rsp_wdata),
        .pop   (bus.rsp_ready && !rsp_empty),
        .rdata (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty)
    );

    assign bus.req_ready    = !req_full;
    assign bus.rsp_valid    = !rsp_empty;
    assign bus.rsp_data     = rsp_head;
    assign bus.gcd_in_valid = (state_q == ISSUE);
    assign bus.gcd_in_data  = (state_q == ISSUE) ? req_head : '0;
    assign bus.err          = err_q;
    assign bus.done_cnt     = done_cnt_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        req_pop   = 1'b0;
        rsp_push  = 1'b0;
        rsp_wdata = '0;
        err_set   = 1'b0;
        case (state_q)
            IDLE: begin
                // !rsp_full reserves a slot for the result before anything is issued
                if (!req_empty && !rsp_full) begin
                    if (req_head[W-1:0] == '0) begin
                        rsp_push  = 1'b1;
                        rsp_wdata = req_head[2*W-1:W];
                        req_pop   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.gcd_in_ready) begin
                    req_pop = 1'b1;
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (timer_q != '1) timer_d = timer_q + 1'b1;
                if (timer_q == TW'(TIMEOUT - 1)) err_set = 1'b1;
                if (bus.gcd_out_valid) begin
                    rsp_push  = 1'b1;
                    rsp_wdata = bus.gcd_out_data;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.gcd_out_valid && state_q != WAIT) err_set = 1'b1;
        err_d      = err_set ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
        done_cnt_d = done_cnt_q + 16'(rsp_push);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            err_q      <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
            done_cnt_q <= done_cnt_d;
        end
    end
endmodule

// File: tb/tb_gcd_driver.sv
// Directed bench for gcd_driver with a behavioural GCD unit on the io_in/io_out side.
module tb_gcd_driver;
    localparam int W  = 16;
    localparam int TO = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gcd_driver_if #(.W(W)) ifc ();

    gcd_driver #(.W(W), .REQ_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifc.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // GCD unit model
    bit          answer_en = 1'b1;
    int          lat       = 2;
    int          spur_req  = 0;
    int          spur_done = 0;
    logic        hs_seen   = 1'b0;
    logic [31:0] hs_data   = '0;
    logic        busy      = 1'b0;
    int          cnt       = 0;
    logic [15:0] res       = '0;
    int          issue_cnt = 0;
    bit          stream    = 1'b0;
    int          rx_cnt    = 0;
    int          bad       = 0;

    function automatic logic [15:0] gcd_f(input logic [15:0] a_in, input logic [15:0] b_in);
        logic [15:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    always @(posedge clk) begin
        hs_seen <= ifc.gcd_in_valid && ifc.gcd_in_ready;
        hs_data <= ifc.gcd_in_data;
        if (ifc.gcd_in_valid && ifc.gcd_in_ready) issue_cnt <= issue_cnt + 1;
        if (stream && ifc.rsp_valid && ifc.rsp_ready) begin
            if (ifc.rsp_data != rx_cnt[15:0]) bad <= bad + 1;
            rx_cnt <= rx_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            busy              <= 1'b0;
            cnt               <= 0;
            ifc.gcd_in_ready  <= 1'b1;
            ifc.gcd_out_valid <= 1'b0;
            ifc.gcd_out_data  <= '0;
        end else begin
            ifc.gcd_out_valid <= 1'b0;
            if (hs_seen && !busy) begin
                busy             <= 1'b1;
                cnt              <= lat;
                res              <= gcd_f(hs_data[31:16], hs_data[15:0]);
                ifc.gcd_in_ready <= 1'b0;
            end else if (busy) begin
                if (cnt == 0) begin
                    busy             <= 1'b0;
                    ifc.gcd_in_ready <= 1'b1;
                    if (answer_en) begin
                        ifc.gcd_out_valid <= 1'b1;
                        ifc.gcd_out_data  <= res;
                    end
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (spur_req != spur_done) begin
                spur_done         <= spur_req;
                ifc.gcd_out_valid <= 1'b1;
                ifc.gcd_out_data  <= 16'hdead;
            end
        end
    end

    // Tasks start and end on a falling edge.
    task automatic send(input logic [15:0] x, input logic [15:0] y);
        int k;
        ifc.req_valid = 1'b1;
        ifc.req_data  = {x, y};
        for (k = 0; k < 300 && !ifc.req_ready; k++) @(negedge clk);
        if (!ifc.req_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: req_ready=0, required 1 for {%0d,%0d}", x, y);
        end
        @(negedge clk);
        ifc.req_valid = 1'b0;
    endtask

    task automatic recv(input string nm, input logic [15:0] exp);
        int k;
        for (k = 0; k < 300 && !ifc.rsp_valid; k++) @(negedge clk);
        if (!ifc.rsp_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: rsp_valid=0, required 1", nm);
        end else begin
            chk(nm, 32'(ifc.rsp_data), 32'(exp));
        end
        ifc.rsp_ready = 1'b1;
        @(negedge clk);
        ifc.rsp_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_req_ready"},    32'(ifc.req_ready),    32'd1);
        chk({pfx, "_rsp_valid"},    32'(ifc.rsp_valid),    32'd0);
        chk({pfx, "_gcd_in_valid"}, 32'(ifc.gcd_in_valid), 32'd0);
        chk({pfx, "_gcd_in_data"},  ifc.gcd_in_data,       32'd0);
        chk({pfx, "_err"},          32'(ifc.err),          32'd0);
        chk({pfx, "_done_cnt"},     32'(ifc.done_cnt),     32'd0);
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] r;
        bit          iss;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ic0, dc0, n, sent, cyc, k;
        bit acc, seen;

        tbl[0] = '{16'd100,   16'd75,  16'd25,    1'b1};
        tbl[1] = '{16'd17,    16'd5,   16'd1,     1'b1};
        tbl[2] = '{16'd0,     16'd9,   16'd9,     1'b1};
        tbl[3] = '{16'd12,    16'd8,   16'd4,     1'b1};
        tbl[4] = '{16'd65535, 16'd0,   16'd65535, 1'b0};
        tbl[5] = '{16'd0,     16'd0,   16'd0,     1'b0};
        tbl[6] = '{16'd1071,  16'd462, 16'd21,    1'b1};
        tbl[7] = '{16'd255,   16'd85,  16'd85,    1'b1};
        tbl[8] = '{16'd7,     16'd0,   16'd7,     1'b0};
        tbl[9] = '{16'd9,     16'd27,  16'd9,     1'b1};

        ifc.req_valid = 1'b0;
        ifc.req_data  = '0;
        ifc.rsp_ready = 1'b0;
        ifc.err_clr   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // {48,18}: issue two cycles after acceptance, result 6
        send(16'd48, 16'd18);
        chk("t1_in_valid_t1", 32'(ifc.gcd_in_valid), 32'd0);
        @(negedge clk);
        chk("t1_in_valid_t2", 32'(ifc.gcd_in_valid), 32'd1);
        chk("t1_in_data",     ifc.gcd_in_data,       32'h0030_0012);
        recv("t1_rsp", 16'd6);
        chk("t1_done_cnt", 32'(ifc.done_cnt), 32'd1);

        // {7,0}: local bypass, visible two cycles after acceptance
        ic0 = issue_cnt;
        send(16'd7, 16'd0);
        chk("t2_rsp_valid_t1", 32'(ifc.rsp_valid), 32'd0);
        @(negedge clk);
        chk("t2_rsp_valid_t2", 32'(ifc.rsp_valid), 32'd1);
        chk("t2_rsp_data",     32'(ifc.rsp_data),  32'd7);
        chk("t2_no_issue",     32'(issue_cnt - ic0), 32'd0);
        recv("t2_rsp", 16'd7);
        chk("t2_done_cnt", 32'(ifc.done_cnt), 32'd2);

        for (int i = 0; i < 10; i++) begin
            ic0 = issue_cnt;
            dc0 = int'(ifc.done_cnt);
            send(tbl[i].x, tbl[i].y);
            recv($sformatf("tbl%0d_rsp", i), tbl[i].r);
            chk($sformatf("tbl%0d_issued", i), 32'(issue_cnt != ic0), 32'(tbl[i].iss));
            chk($sformatf("tbl%0d_done", i), 32'(ifc.done_cnt), 32'(dc0 + 1));
        end

        // Backpressure: 4 results fill the rsp FIFO, 4 more requests fill the req FIFO
        dc0 = int'(ifc.done_cnt);
        for (int i = 0; i < 8; i++) send(16'((i + 1) * 7), 16'((i + 1) * 14));
        repeat (30) @(negedge clk);
        chk("t3_rsp_valid", 32'(ifc.rsp_valid), 32'd1);
        chk("t3_req_full",  32'(ifc.req_ready), 32'd0);
        chk("t3_done4",     32'(ifc.done_cnt),  32'(dc0 + 4));
        ic0 = issue_cnt;
        n   = 0;
        for (k = 0; k < 10; k++) begin
            if (ifc.gcd_in_valid) n++;
            @(negedge clk);
        end
        chk("t3_hold_idle", 32'(n), 32'd0);
        chk("t3_no_issue",  32'(issue_cnt - ic0), 32'd0);
        for (int i = 0; i < 8; i++) recv($sformatf("t3_drain%0d", i), 16'((i + 1) * 7));
        repeat (3) @(negedge clk);
        chk("t3_done8", 32'(ifc.done_cnt), 32'(dc0 + 8));

        // Reset in the middle of WAIT with a queued response
        send(16'd5, 16'd0);
        lat = 50;
        ic0 = issue_cnt;
        send(16'd48, 16'd18);
        for (k = 0; k < 50 && issue_cnt == ic0; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("t5_pre_rsp_valid", 32'(ifc.rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("t5_async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lat   = 2;
        @(negedge clk);
        send(16'd12, 16'd8);
        recv("t5_after_rst", 16'd4);
        chk("t5_done_cnt", 32'(ifc.done_cnt), 32'd1);

        // Timeout: GCD never answers
        answer_en = 1'b0;
        send(16'd48, 16'd18);
        for (k = 0; k < 20 && !ifc.gcd_in_valid; k++) @(negedge clk);
        @(posedge clk);
        n = 0;
        for (k = 0; k < 200; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ifc.err) break;
        end
        chk("t4_timeout_cycles", 32'(n), 32'd64);
        chk("t4_err_set", 32'(ifc.err), 32'd1);
        ifc.err_clr = 1'b1;
        @(negedge clk);
        ifc.err_clr = 1'b0;
        chk("t4_err_clr", 32'(ifc.err), 32'd0);
        repeat (150) @(negedge clk);
        chk("t4_err_stays_clr", 32'(ifc.err), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        answer_en = 1'b1;
        repeat (2) @(negedge clk);

        // Spurious result in IDLE
        spur_req++;
        repeat (4) @(negedge clk);
        chk("t4_spur_err",      32'(ifc.err),       32'd1);
        chk("t4_spur_no_push",  32'(ifc.rsp_valid), 32'd0);
        chk("t4_spur_done_cnt", 32'(ifc.done_cnt),  32'd0);
        ifc.err_clr = 1'b1;
        @(negedge clk);
        chk("t4_spur_clr", 32'(ifc.err), 32'd0);
        spur_req++;
        seen = 1'b0;
        for (k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ifc.err) seen = 1'b1;
        end
        ifc.err_clr = 1'b0;
        chk("t4_set_beats_clr", 32'(seen), 32'd1);

        // 65537 bypass requests streamed with the host always ready
        chk("t6_start_done", 32'(ifc.done_cnt), 32'd0);
        stream        = 1'b1;
        ifc.rsp_ready = 1'b1;
        sent          = 0;
        cyc           = 0;
        while (sent < 65537 && cyc < 80000) begin
            ifc.req_valid = 1'b1;
            ifc.req_data  = {sent[15:0], 16'h0000};
            acc           = ifc.req_ready;
            @(negedge clk);
            if (acc) sent++;
            cyc++;
        end
        ifc.req_valid = 1'b0;
        for (k = 0; k < 100 && rx_cnt < 65537; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("t6_sent",     32'(sent),          32'd65537);
        chk("t6_rx_cnt",   32'(rx_cnt),        32'd65537);
        chk("t6_rx_order", 32'(bad),           32'd0);
        chk("t6_done_wrap", 32'(ifc.done_cnt), 32'd1);
        chk("t6_rsp_empty", 32'(ifc.rsp_valid), 32'd0);
        chk("t6_req_empty", 32'(ifc.req_ready), 32'd1);
        stream        = 1'b0;
        ifc.rsp_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
